// File: rtl/cnn_div_pkg.sv
// Shared constants for the conv requantisation divider (cnn_div_seq_22s_14s).
package cnn_div_pkg;

    localparam int unsigned DIV_DIVIDEND_W = 22;
    localparam int unsigned DIV_DIVISOR_W  = 14;
    localparam int unsigned DIV_QUOTIENT_W = 8;
    localparam int unsigned DIV_CNT_W      = $clog2(DIV_DIVIDEND_W + 1);

    localparam int QUO_MAX = (1 << (DIV_QUOTIENT_W - 1)) - 1;
    localparam int QUO_MIN = -(1 << (DIV_QUOTIENT_W - 1));

    typedef logic [1:0] div_state_t;
    localparam div_state_t S_IDLE = 2'd0;
    localparam div_state_t S_CALC = 2'd1;
    localparam div_state_t S_FIX  = 2'd2;
    localparam div_state_t S_DONE = 2'd3;

endpackage

// File: rtl/cnn_div_fix.sv
// Sign restoration plus saturation (CNN_DIV_SAT_EN) or two's-complement wrap
// of the unsigned quotient/remainder magnitudes.
module cnn_div_fix
    import cnn_div_pkg::*;
#(
    parameter int unsigned DW   = DIV_DIVIDEND_W,
    parameter int unsigned DSW  = DIV_DIVISOR_W,
    parameter int unsigned QW   = DIV_QUOTIENT_W,
    parameter int          QMAX = QUO_MAX,
    parameter int          QMIN = QUO_MIN
) (
    input  logic [DW-1:0]  qmag,
    input  logic [DSW-1:0] rmag,
    input  logic           sn,
    input  logic           sd,
    input  logic           dz,
    output logic [QW-1:0]  quotient_c,
    output logic [DSW-1:0] remainder_c,
    output logic           ovf_c
);

    logic [DW:0]        qext;
    logic signed [DW:0] qs;
    logic [DSW-1:0]     rs;

    // Quotient truncates toward zero; remainder follows the dividend's sign.
    assign qext = {1'b0, qmag};
    assign qs   = (sn ^ sd) ? $signed(~qext + (DW + 1)'(1)) : $signed(qext);
    assign rs   = sn ? (~rmag + DSW'(1)) : rmag;

`ifdef CNN_DIV_SAT_EN
    localparam logic signed [DW:0] QMAX_X = (DW + 1)'(QMAX);
    localparam logic signed [DW:0] QMIN_X = (DW + 1)'(QMIN);
`endif

    always_comb begin
        quotient_c  = qs[QW-1:0];
        remainder_c = rs;
        ovf_c       = 1'b0;
`ifdef CNN_DIV_SAT_EN
        if (qs > QMAX_X) begin
            quotient_c = QW'(QMAX);
            ovf_c      = 1'b1;
        end else if (qs < QMIN_X) begin
            quotient_c = QW'(QMIN);
            ovf_c      = 1'b1;
        end
`endif
        if (dz) begin
            quotient_c  = sn ? QW'(QMIN) : QW'(QMAX);
            remainder_c = '0;
            ovf_c       = 1'b0;
        end
    end

endmodule

// File: rtl/cnn_div_seq_22s_14s.sv
// Sequential restoring signed divider, one quotient bit per clock, valid/ready
// on both sides. Saturating quotient when CNN_DIV_SAT_EN is defined, else wraps.
module cnn_div_seq_22s_14s
    import cnn_div_pkg::*;
#(
    parameter int unsigned DIVIDEND_WIDTH = DIV_DIVIDEND_W,
    parameter int unsigned DIVISOR_WIDTH  = DIV_DIVISOR_W,
    parameter int unsigned QUOTIENT_WIDTH = DIV_QUOTIENT_W
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [QUOTIENT_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder,
    output logic                      ovf,
    output logic                      dz
);

    localparam int unsigned DW    = DIVIDEND_WIDTH;
    localparam int unsigned DSW   = DIVISOR_WIDTH;
    localparam int unsigned QW    = QUOTIENT_WIDTH;
    localparam int unsigned CNT_W = (DW == DIV_DIVIDEND_W) ? DIV_CNT_W : $clog2(DW + 1);

    div_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [DW-1:0]  acc_q;
    logic [DSW-1:0] rem_q;
    logic [DSW-1:0] dvs_q;
    logic           sn_q, sd_q, dz_q;

    logic           accept, div_zero, last_iter;
    logic [DW-1:0]  dvd_mag_c;
    logic [DSW-1:0] dvs_mag_c;
    logic [DSW:0]   trial_c, diff_c;
    logic           ge_c;
    logic [QW-1:0]  fix_q_c;
    logic [DSW-1:0] fix_r_c;
    logic           fix_ovf_c;

    assign accept    = in_valid && in_ready;
    assign div_zero  = (divisor == '0);
    assign last_iter = (cnt_q == CNT_W'(DW - 1));
    // -2^(W-1) negates to itself, which is the correct unsigned magnitude.
    assign dvd_mag_c = dividend[DW-1] ? (~dividend + DW'(1)) : dividend;
    assign dvs_mag_c = divisor[DSW-1] ? (~divisor + DSW'(1)) : divisor;

    // Restoring step: acc_q shifts dividend bits out of its MSB and quotient bits into its LSB.
    assign trial_c = {rem_q, acc_q[DW-1]};
    assign ge_c    = (trial_c >= {1'b0, dvs_q});
    assign diff_c  = trial_c - {1'b0, dvs_q};

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid) state_d = div_zero ? S_FIX : S_CALC;
            S_CALC: if (last_iter) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            cnt_q <= '0;
            acc_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            sn_q  <= 1'b0;
            sd_q  <= 1'b0;
            dz_q  <= 1'b0;
        end else if (accept) begin
            cnt_q <= '0;
            acc_q <= dvd_mag_c;
            rem_q <= '0;
            dvs_q <= dvs_mag_c;
            sn_q  <= dividend[DW-1];
            sd_q  <= divisor[DSW-1];
            dz_q  <= div_zero;
        end else if (state_q == S_CALC) begin
            cnt_q <= cnt_q + CNT_W'(1);
            acc_q <= {acc_q[DW-2:0], ge_c};
            rem_q <= ge_c ? diff_c[DSW-1:0] : trial_c[DSW-1:0];
        end
    end

    cnn_div_fix #(
        .DW   (DW),
        .DSW  (DSW),
        .QW   (QW),
        .QMAX ((1 << (QW - 1)) - 1),
        .QMIN (-(1 << (QW - 1)))
    ) u_fix (
        .qmag        (acc_q),
        .rmag        (rem_q),
        .sn          (sn_q),
        .sd          (sd_q),
        .dz          (dz_q),
        .quotient_c  (fix_q_c),
        .remainder_c (fix_r_c),
        .ovf_c       (fix_ovf_c)
    );

    // Handshake flags follow the next state so they are pure registers.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            ovf       <= 1'b0;
            dz        <= 1'b0;
        end else begin
            in_ready  <= (state_d == S_IDLE);
            out_valid <= (state_d == S_DONE);
            if (state_q == S_FIX) begin
                quotient  <= fix_q_c;
                remainder <= fix_r_c;
                ovf       <= fix_ovf_c;
                dz        <= dz_q;
            end
        end
    end

endmodule

// File: tb/tb_cnn_div_seq_22s_14s.sv
// Scoreboard bench for cnn_div_seq_22s_14s: directed sign/boundary/dz/backpressure/reset cases plus random.
module tb_cnn_div_seq_22s_14s;
    import cnn_div_pkg::*;

    localparam int unsigned DW  = DIV_DIVIDEND_W;
    localparam int unsigned DSW = DIV_DIVISOR_W;
    localparam int unsigned QW  = DIV_QUOTIENT_W;

    logic           ap_clk = 1'b0;
    logic           ap_rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [DW-1:0]  dividend = '0;
    logic [DSW-1:0] divisor = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [QW-1:0]  quotient;
    logic [DSW-1:0] remainder;
    logic           ovf;
    logic           dz;

    cnn_div_seq_22s_14s dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf),
        .dz        (dz)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        int q;
        int r;
        int ovf;
        int dz;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input int n, input int d);
        exp_t e;
        int   qt;
        logic signed [7:0] w;
        e.ovf = 0;
        e.dz  = 0;
        e.lat = 23;
        if (d == 0) begin
            e.q   = (n >= 0) ? 127 : -128;
            e.r   = 0;
            e.dz  = 1;
            e.lat = 1;
        end else begin
            qt  = n / d;
            e.r = n % d;
            w   = 8'(qt);
            e.q = int'(w);
`ifdef CNN_DIV_SAT_EN
            if (qt > 127) begin
                e.q = 127;
                e.ovf = 1;
            end else if (qt < -128) begin
                e.q = -128;
                e.ovf = 1;
            end
`endif
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        chk({tag, "_q"},   int'($signed(quotient)),  e.q);
        chk({tag, "_r"},   int'($signed(remainder)), e.r);
        chk({tag, "_ovf"}, int'(ovf), e.ovf);
        chk({tag, "_dz"},  int'(dz),  e.dz);
    endtask

    task automatic run_op(input string tag, input int n, input int d, input int stall, input bit hold_chk);
        exp_t e;
        int   cyc;
        cyc = 0;
        while (!in_ready && cyc < 100) begin
            tick();
            cyc++;
        end
        chk({tag, "_in_ready_idle"}, int'(in_ready), 1);
        dividend = DW'(n);
        divisor  = DSW'(d);
        in_valid = 1'b1;
        sb.push_back(model(n, d));
        tick();
        in_valid = 1'b0;
        chk({tag, "_in_ready_busy"}, int'(in_ready), 0);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        chk({tag, "_latency"}, cyc, sb[0].lat);
        for (int i = 0; i < stall; i++) begin
            if (hold_chk) begin
                check_outputs({tag, "_hold"}, sb[0]);
                chk({tag, "_hold_valid"}, int'(out_valid), 1);
                chk({tag, "_hold_in_ready"}, int'(in_ready), 0);
            end
            tick();
        end
        e = sb.pop_front();
        check_outputs(tag, e);
        chk({tag, "_valid"}, int'(out_valid), 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, int'(out_valid), 0);
        chk({tag, "_in_ready_back"}, int'(in_ready), 1);
    endtask

    initial begin
        exp_t zero_e;
        exp_t dropped;
        logic signed [21:0] rn;
        logic signed [13:0] rd;
        int   n, d;

        zero_e = '{q: 0, r: 0, ovf: 0, dz: 0, lat: 0};
        repeat (3) tick();
        check_outputs("reset", zero_e);
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_in_ready", int'(in_ready), 1);
        ap_rst = 1'b0;
        tick();

        run_op("pos_pos", 100, 7, 0, 0);
        run_op("neg_pos", -100, 7, 1, 0);
        run_op("pos_neg", 100, -7, 2, 0);
        run_op("min_edge", -1024, 8, 0, 0);
        run_op("sat_edge", -2097152, -8192, 0, 0);
        run_op("dz_pos", 5, 0, 0, 0);
        run_op("dz_neg", -5, 0, 1, 0);
        run_op("hold", -300, 11, 10, 1);
        run_op("after_hold", 1000, 7, 0, 0);

        // Abort an operation part way through CALC.
        dividend = DW'(100);
        divisor  = DSW'(7);
        in_valid = 1'b1;
        sb.push_back(model(100, 7));
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        ap_rst = 1'b1;
        #1;
        check_outputs("midrst", zero_e);
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        dropped = sb.pop_back();
        chk("midrst_sb_empty", sb.size(), 0);
        tick();
        ap_rst = 1'b0;
        tick();
        run_op("post_rst", 100, 7, 0, 0);

        for (int k = 0; k < 1500; k++) begin
            rn = 22'($urandom);
            rd = 14'($urandom);
            n  = int'(rn);
            d  = int'(rd);
            if ($urandom_range(0, 3) == 0) n = int'($urandom_range(0, 2000)) - 1000;
            case ($urandom_range(0, 9))
                0:       d = 0;
                1, 2, 3: d = int'($urandom_range(0, 40)) - 20;
                default: ;
            endcase
            run_op("rand", n, d, int'($urandom_range(0, 3)), 0);
        end

        chk("final_sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
